// File: rtl/store_buffer.sv
// store_buffer: word-store FIFO between the MEM stage and data_memory.
// Define STORE_BUF_FWD_EN to forward matching loads; otherwise matching loads stall until drained.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic                     ld_valid,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hit,
   output logic [31:0]              ld_data,
   output logic                     stall,
   output logic                     mem_write,
   output logic [31:0]              mem_address,
   output logic [31:0]              mem_write_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic          match_any;
   logic          ld_conflict;
   logic          drain_en;
   logic          push;
`ifdef STORE_BUF_FWD_EN
   logic [31:0]   match_data;
`endif

   // Walk oldest to youngest so the last match seen is the youngest entry.
   always_comb begin
      logic [PW-1:0] idx;
      match_any = 1'b0;
`ifdef STORE_BUF_FWD_EN
      match_data = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((k < 32'(count)) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
            match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
            match_data = data_q[idx];
`endif
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   assign ld_conflict = 1'b0;
   assign ld_hit      = ld_valid && match_any;
   assign ld_data     = ld_hit ? match_data : '0;
`else
   assign ld_conflict = ld_valid && match_any;
   assign ld_hit      = 1'b0;
   assign ld_data     = '0;
`endif

   assign stall          = (st_valid && (count == CW'(DEPTH))) || ld_conflict;
   assign drain_en       = (count != '0) && (!ld_valid || ld_conflict);
   assign push           = st_valid && !stall;

   assign mem_write      = drain_en;
   assign mem_address    = addr_q[head];
   assign mem_write_data = data_q[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            tail         <= tail + PW'(1);
         end
         if (drain_en) begin
            head <= head + PW'(1);
         end
         case ({push, drain_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
// Honours STORE_BUF_FWD_EN the same way as the design.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = '0;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        stall;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [2:0]  count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_hit(ld_hit), .ld_data(ld_data), .stall(stall),
      .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .count(count)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: pending stores in program order plus a memory image.
   typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
   ent_t        mq[$];
   logic [31:0] mdl_mem [logic [31:0]];
   logic [63:0] mdl_log[$];
   logic [31:0] dut_mem [logic [31:0]];
   logic [63:0] dut_log[$];

   logic        e_hit, e_stall, e_mw, e_push;
   logic [31:0] e_ld, e_ma, e_md;
   int          e_cnt;

   always @(posedge clk) begin
      if (mem_write) begin
         dut_mem[mem_address] = mem_write_data;
         dut_log.push_back({mem_address, mem_write_data});
      end
   end

   function automatic void predict();
      logic        m = 1'b0;
      logic [31:0] md = '0;
      logic        conflict;
      foreach (mq[i]) if (mq[i].a[31:2] == ld_addr[31:2]) begin m = 1'b1; md = mq[i].d; end
      conflict = !FWD && ld_valid && m;
      e_hit   = FWD && ld_valid && m;
      e_ld    = e_hit ? md : 32'h0;
      e_cnt   = mq.size();
      e_stall = (st_valid && mq.size() == DEPTH) || conflict;
      e_mw    = (mq.size() != 0) && (!ld_valid || conflict);
      e_ma    = (mq.size() != 0) ? mq[0].a : 32'h0;
      e_md    = (mq.size() != 0) ? mq[0].d : 32'h0;
      e_push  = st_valid && !e_stall;
   endfunction

   function automatic void commit();
      ent_t e;
      if (e_mw) begin
         mdl_mem[mq[0].a] = mq[0].d;
         mdl_log.push_back({mq[0].a, mq[0].d});
         void'(mq.pop_front());
      end
      if (rst) mq.delete();
      else if (e_push) begin
         e.a = st_addr; e.d = st_data;
         mq.push_back(e);
      end
   endfunction

   task automatic apply(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la);
      @(negedge clk);
      rst = r; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
      #1;
      predict();
   endtask

   task automatic advance();
      @(posedge clk);
      commit();
   endtask

   task automatic test_reset();
      apply(1, 0, 0, 0, 0, 0); advance();
      apply(0, 0, 0, 0, 0, 0);
      checks += 5;
      if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
      if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
      if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", stall); end
      if (ld_hit !== 1'b0) begin failures++; $display("FAIL reset_ld_hit got %b exp 0", ld_hit); end
      if (ld_data !== 32'h0) begin failures++; $display("FAIL reset_ld_data got %h exp 0", ld_data); end
      advance();
   endtask

   task automatic test_single_store();
      apply(0, 1, 32'h10, 32'hAABBCCDD, 0, 0);
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL single_stall got %b exp 0", stall); end
      if (mem_write !== 1'b0) begin failures++; $display("FAIL single_mw0 got %b exp 0", mem_write); end
      advance();
      apply(0, 0, 0, 0, 0, 0);
      checks += 4;
      if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got %0d exp 1", count); end
      if (mem_write !== 1'b1) begin failures++; $display("FAIL single_mw got %b exp 1", mem_write); end
      if (mem_address !== 32'h10) begin failures++; $display("FAIL single_addr got %h exp 00000010", mem_address); end
      if (mem_write_data !== 32'hAABBCCDD) begin failures++; $display("FAIL single_data got %h exp aabbccdd", mem_write_data); end
      advance();
      apply(0, 0, 0, 0, 0, 0);
      checks += 2;
      if (count !== 3'd0) begin failures++; $display("FAIL single_count0 got %0d exp 0", count); end
      if (mem_write !== 1'b0) begin failures++; $display("FAIL single_mw_idle got %b exp 0", mem_write); end
      advance();
   endtask

   task automatic test_full_stall();
      logic [31:0] exp_a [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, exp_a[i], 32'h100 + i, 1, 32'h200);
         checks++;
         if (stall !== 1'b0) begin failures++; $display("FAIL full_push%0d_stall got %b exp 0", i, stall); end
         advance();
      end
      apply(0, 1, 32'h10, 32'h104, 1, 32'h200);
      checks += 3;
      if (count !== 3'd4) begin failures++; $display("FAIL full_count got %0d exp 4", count); end
      if (mem_write !== 1'b0) begin failures++; $display("FAIL full_blocked_mw got %b exp 0", mem_write); end
      if (stall !== 1'b1) begin failures++; $display("FAIL full_stall got %b exp 1", stall); end
      advance();
      // Store held while the first drain happens: still stalled because count is at DEPTH.
      apply(0, 1, 32'h10, 32'h104, 0, 0);
      checks += 2;
      if (stall !== 1'b1) begin failures++; $display("FAIL full_drain_stall got %b exp 1", stall); end
      if (mem_write !== 1'b1 || mem_address !== 32'h0) begin failures++; $display("FAIL full_w0 got mw=%b a=%h exp mw=1 a=0", mem_write, mem_address); end
      advance();
      apply(0, 1, 32'h10, 32'h104, 0, 0);
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL full_accept_stall got %b exp 0", stall); end
      if (mem_write !== 1'b1 || mem_address !== 32'h4) begin failures++; $display("FAIL full_w1 got mw=%b a=%h exp mw=1 a=4", mem_write, mem_address); end
      advance();
      for (int i = 2; i < 5; i++) begin
         apply(0, 0, 0, 0, 0, 0);
         checks++;
         if (mem_write !== 1'b1 || mem_address !== exp_a[i] || mem_write_data !== 32'h100 + i)
            begin failures++; $display("FAIL full_w%0d got mw=%b a=%h d=%h exp mw=1 a=%h d=%h", i, mem_write, mem_address, mem_write_data, exp_a[i], 32'h100 + i); end
         advance();
      end
      apply(0, 0, 0, 0, 0, 0);
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL full_empty got %0d exp 0", count); end
      advance();
   endtask

   task automatic test_forward();
      apply(0, 1, 32'h20, 32'h5, 1, 32'h200); advance();
      apply(0, 1, 32'h30, 32'h6, 1, 32'h200); advance();
      if (FWD) begin
         apply(0, 0, 0, 0, 1, 32'h30);
         checks += 3;
         if (ld_hit !== 1'b1 || ld_data !== 32'h6) begin failures++; $display("FAIL fwd_hit30 got hit=%b d=%h exp hit=1 d=6", ld_hit, ld_data); end
         if (stall !== 1'b0) begin failures++; $display("FAIL fwd_stall got %b exp 0", stall); end
         if (mem_write !== 1'b0) begin failures++; $display("FAIL fwd_mw got %b exp 0", mem_write); end
         advance();
         apply(0, 1, 32'h20, 32'h2, 1, 32'h200); advance();
         apply(0, 0, 0, 0, 1, 32'h23);
         checks++;
         if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin failures++; $display("FAIL fwd_youngest got hit=%b d=%h exp hit=1 d=2", ld_hit, ld_data); end
         advance();
         apply(0, 0, 0, 0, 1, 32'h24);
         checks++;
         if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin failures++; $display("FAIL fwd_miss got hit=%b d=%h exp hit=0 d=0", ld_hit, ld_data); end
         advance();
      end else begin
         for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 1, 32'h30);
            checks += 2;
            if (stall !== 1'b1) begin failures++; $display("FAIL conf_stall%0d got %b exp 1", i, stall); end
            if (mem_write !== 1'b1 || mem_address !== (i == 0 ? 32'h20 : 32'h30))
               begin failures++; $display("FAIL conf_w%0d got mw=%b a=%h", i, mem_write, mem_address); end
            advance();
         end
         apply(0, 0, 0, 0, 1, 32'h30);
         checks += 3;
         if (stall !== 1'b0) begin failures++; $display("FAIL conf_release got %b exp 0", stall); end
         if (ld_hit !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL conf_idle got hit=%b mw=%b exp 0 0", ld_hit, mem_write); end
         if (!dut_mem.exists(32'h30) || dut_mem[32'h30] !== 32'h6) begin failures++; $display("FAIL conf_mem30 exp 00000006"); end
         advance();
      end
      for (int i = 0; i < 6; i++) begin apply(0, 0, 0, 0, 0, 0); advance(); end
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL fwd_drained got %0d exp 0", count); end
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int budget = 0;
      int l0 = dut_log.size();
      int m0 = mdl_log.size();
      while (pushed < 10 && budget < 200) begin
         if ($urandom_range(0, 2) != 0) apply(0, 1, 32'h100 + 4 * pushed, $urandom, 0, 0);
         else apply(0, 0, 0, 0, $urandom_range(0, 1), 32'h800);
         checks += 2;
         if (mem_write !== e_mw || (e_mw && (mem_address !== e_ma || mem_write_data !== e_md)))
            begin failures++; $display("FAIL wrap_mem got mw=%b a=%h d=%h exp mw=%b a=%h d=%h", mem_write, mem_address, mem_write_data, e_mw, e_ma, e_md); end
         if (stall !== e_stall || int'(count) != e_cnt)
            begin failures++; $display("FAIL wrap_state got stall=%b cnt=%0d exp stall=%b cnt=%0d", stall, count, e_stall, e_cnt); end
         if (e_push) pushed++;
         advance();
         budget++;
      end
      checks++;
      if (pushed != 10) begin failures++; $display("FAIL wrap_budget got %0d pushes exp 10", pushed); end
      for (int i = 0; i < 8; i++) begin apply(0, 0, 0, 0, 0, 0); advance(); end
      checks++;
      if (dut_log.size() - l0 != 10 || mdl_log.size() - m0 != 10)
         begin failures++; $display("FAIL wrap_count got %0d writes exp 10", dut_log.size() - l0); end
      else for (int i = 0; i < 10; i++) begin
         checks++;
         if (dut_log[l0 + i] !== mdl_log[m0 + i] || dut_log[l0 + i][63:32] !== 32'h100 + 4 * i)
            begin failures++; $display("FAIL wrap_order%0d got %h exp %h", i, dut_log[l0 + i], mdl_log[m0 + i]); end
      end
   endtask

   task automatic test_random();
      int op;
      for (int c = 0; c < 300; c++) begin
         op = $urandom_range(0, 2);
         if (op == 1) apply(0, 1, 32'h40 + 4 * $urandom_range(0, 7), $urandom, 0, 0);
         else if (op == 2) apply(0, 0, 0, 0, 1, 32'h40 + $urandom_range(0, 35));
         else apply(0, 0, 0, 0, 0, 0);
         checks += 3;
         if (ld_hit !== e_hit || ld_data !== e_ld)
            begin failures++; $display("FAIL rand_fwd got hit=%b d=%h exp hit=%b d=%h", ld_hit, ld_data, e_hit, e_ld); end
         if (stall !== e_stall || int'(count) != e_cnt)
            begin failures++; $display("FAIL rand_state got stall=%b cnt=%0d exp stall=%b cnt=%0d", stall, count, e_stall, e_cnt); end
         if (mem_write !== e_mw || (e_mw && (mem_address !== e_ma || mem_write_data !== e_md)))
            begin failures++; $display("FAIL rand_mem got mw=%b a=%h d=%h exp mw=%b a=%h d=%h", mem_write, mem_address, mem_write_data, e_mw, e_ma, e_md); end
         advance();
      end
      for (int i = 0; i < 6; i++) begin apply(0, 0, 0, 0, 0, 0); advance(); end
      foreach (mdl_mem[a]) begin
         checks++;
         if (!dut_mem.exists(a) || dut_mem[a] !== mdl_mem[a])
            begin failures++; $display("FAIL rand_memimg at %h exp %h", a, mdl_mem[a]); end
      end
   endtask

   task automatic test_reset_mid();
      int l0;
      for (int i = 0; i < 3; i++) begin apply(0, 1, 32'h300 + 4 * i, 32'hF0 + i, 1, 32'h900); advance(); end
      apply(0, 0, 0, 0, 1, 32'h900);
      checks++;
      if (count !== 3'd3) begin failures++; $display("FAIL rmid_pending got %0d exp 3", count); end
      advance();
      apply(1, 0, 0, 0, 1, 32'h900); advance();
      l0 = dut_log.size();
      for (int i = 0; i < 5; i++) begin
         apply(0, 0, 0, 0, 0, 0);
         checks += 2;
         if (count !== 3'd0) begin failures++; $display("FAIL rmid_count%0d got %0d exp 0", i, count); end
         if (mem_write !== 1'b0) begin failures++; $display("FAIL rmid_mw%0d got %b exp 0", i, mem_write); end
         advance();
      end
      checks++;
      if (dut_log.size() != l0) begin failures++; $display("FAIL rmid_writes got %0d exp 0", dut_log.size() - l0); end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_full_stall();
      test_forward();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
